// File: rtl/phase_sequencer.sv
// Multicycle phase sequencer: one-hot fetch..writeback phases with stalls,
// start/halt control, stuck-stall watchdog and cycle/instret counters.
module phase_sequencer #(
    parameter int CNT_W     = 64,
    parameter int WDT_LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             stall_fetch,
    input  logic             stall_decode,
    input  logic             stall_execute,
    input  logic             stall_memoryaccess,
    input  logic             stall_writeback,
    output logic             phase_fetch,
    output logic             phase_decode,
    output logic             phase_execute,
    output logic             phase_memoryaccess,
    output logic             phase_writeback,
    output logic             busy,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);

    localparam int WDT_W = $clog2(WDT_LIMIT + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_LIMIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEMACC,
        WB,
        HALT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WDT_W-1:0] wdt;
    logic             halt_pend;
    logic             stall_cur;
    logic             trip;
    logic             retire;

    assign phase_fetch        = (state == FETCH);
    assign phase_decode       = (state == DECODE);
    assign phase_execute      = (state == EXECUTE);
    assign phase_memoryaccess = (state == MEMACC);
    assign phase_writeback    = (state == WB);
    assign halted             = (state == HALT);
    assign busy = phase_fetch | phase_decode | phase_execute
                | phase_memoryaccess | phase_writeback;

    // Only the stall of the phase currently active matters.
    always_comb begin
        stall_cur = 1'b0;
        unique case (state)
            FETCH:   stall_cur = stall_fetch;
            DECODE:  stall_cur = stall_decode;
            EXECUTE: stall_cur = stall_execute;
            MEMACC:  stall_cur = stall_memoryaccess;
            WB:      stall_cur = stall_writeback;
            default: stall_cur = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        trip      = 1'b0;
        retire    = 1'b0;
        unique case (state)
            IDLE, HALT: begin
                if (start) state_nxt = FETCH;
            end
            FETCH, DECODE, EXECUTE, MEMACC, WB: begin
                if (stall_cur) begin
                    // Trip at the end of the WDT_LIMIT-th stalled cycle.
                    if (wdt >= WDT_LAST) begin
                        state_nxt = HALT;
                        trip      = 1'b1;
                    end
                end else begin
                    unique case (state)
                        FETCH:   state_nxt = DECODE;
                        DECODE:  state_nxt = EXECUTE;
                        EXECUTE: state_nxt = MEMACC;
                        MEMACC:  state_nxt = WB;
                        default: begin
                            retire    = 1'b1;
                            state_nxt = (halt_pend || halt_req) ? HALT : FETCH;
                        end
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wdt         <= '0;
            halt_pend   <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            instret     <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                wdt <= '0;
            end else if (busy && stall_cur) begin
                wdt <= wdt + WDT_W'(1);
            end
            if (state_nxt == HALT) begin
                halt_pend <= 1'b0;
            end else if (busy && halt_req) begin
                halt_pend <= 1'b1;
            end
            if (trip) begin
                timeout <= 1'b1;
            end else if (state == HALT && start) begin
                timeout <= 1'b0;
            end
            if (busy) cycle_count <= cycle_count + CNT_W'(1);
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios plus randomized stimulus
// against a phase-index reference model; a 4-bit-counter twin checks wrap.
module tb_phase_sequencer;

    localparam int LIM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       halt_req;
    logic [4:0] st;

    logic        pf, pd, pe, pm, pw, bsy, hlt, tmo;
    logic [63:0] cc, ir;
    logic        pf_n, pd_n, pe_n, pm_n, pw_n, bsy_n, hlt_n, tmo_n;
    logic [3:0]  cc_n, ir_n;

    logic [7:0] obs, obs_n;
    assign obs   = {pf, pd, pe, pm, pw, bsy, hlt, tmo};
    assign obs_n = {pf_n, pd_n, pe_n, pm_n, pw_n, bsy_n, hlt_n, tmo_n};

    phase_sequencer #(.CNT_W(64), .WDT_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .stall_fetch(st[0]), .stall_decode(st[1]), .stall_execute(st[2]),
        .stall_memoryaccess(st[3]), .stall_writeback(st[4]),
        .phase_fetch(pf), .phase_decode(pd), .phase_execute(pe),
        .phase_memoryaccess(pm), .phase_writeback(pw),
        .busy(bsy), .halted(hlt), .timeout(tmo),
        .cycle_count(cc), .instret(ir)
    );

    phase_sequencer #(.CNT_W(4), .WDT_LIMIT(LIM)) dut_n (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .stall_fetch(st[0]), .stall_decode(st[1]), .stall_execute(st[2]),
        .stall_memoryaccess(st[3]), .stall_writeback(st[4]),
        .phase_fetch(pf_n), .phase_decode(pd_n), .phase_execute(pe_n),
        .phase_memoryaccess(pm_n), .phase_writeback(pw_n),
        .busy(bsy_n), .halted(hlt_n), .timeout(tmo_n),
        .cycle_count(cc_n), .instret(ir_n)
    );

    int checks = 0;
    int failures = 0;

    // Model: m_ph 0=idle, 1..5 = fetch..writeback, 6=halt.
    int          m_ph = 0;
    int          m_run = 0;
    bit          m_hp = 0;
    bit          m_to = 0;
    logic [63:0] m_cc = '0;
    logic [63:0] m_ir = '0;

    localparam logic [7:0] V_F   = 8'b1000_0100;
    localparam logic [7:0] V_D   = 8'b0100_0100;
    localparam logic [7:0] V_E   = 8'b0010_0100;
    localparam logic [7:0] V_M   = 8'b0001_0100;
    localparam logic [7:0] V_W   = 8'b0000_1100;
    localparam logic [7:0] V_H   = 8'b0000_0010;
    localparam logic [7:0] V_HT  = 8'b0000_0011;

    function automatic logic [7:0] mdl_vec();
        logic [7:0] v;
        v = '0;
        if (m_ph >= 1 && m_ph <= 5) begin
            v[8 - m_ph] = 1'b1;
            v[2] = 1'b1;
        end
        v[1] = (m_ph == 6);
        v[0] = m_to;
        return v;
    endfunction

    task automatic mdl(input logic r, s, h, input logic [4:0] stl);
        if (r) begin
            m_ph = 0; m_run = 0; m_hp = 0; m_to = 0;
            m_cc = '0; m_ir = '0;
        end else if (m_ph == 0) begin
            if (s) m_ph = 1;
        end else if (m_ph == 6) begin
            if (s) begin
                m_ph = 1;
                m_to = 0;
            end
        end else begin
            m_cc = m_cc + 64'd1;
            if (h) m_hp = 1;
            if (stl[m_ph - 1]) begin
                m_run++;
                if (m_run == LIM) begin
                    m_ph = 6; m_to = 1; m_hp = 0; m_run = 0;
                end
            end else begin
                m_run = 0;
                if (m_ph < 5) begin
                    m_ph++;
                end else begin
                    m_ir = m_ir + 64'd1;
                    if (m_hp) begin
                        m_ph = 6;
                        m_hp = 0;
                    end else begin
                        m_ph = 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, s, h, input logic [4:0] stl);
        rst = r; start = s; halt_req = h; st = stl;
        @(posedge clk);
        mdl(r, s, h, stl);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        checks++;
        if (obs !== 8'h00 || obs_n !== 8'h00) begin
            failures++;
            $display("FAIL reset_vec got %b/%b want 00000000", obs, obs_n);
        end
        checks++;
        if (cc !== 64'd0 || ir !== 64'd0) begin
            failures++;
            $display("FAIL reset_cnt got cc=%0d ir=%0d want 0/0", cc, ir);
        end
        step(1, 1, 0, 0);
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL reset_over_start got %b want 00000000", obs);
        end
        step(0, 0, 1, 0);
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL idle_halt_req got %b want 00000000", obs);
        end
    endtask

    task automatic test_basic();
        logic [7:0] want;
        step(0, 1, 0, 0);
        checks++;
        if (obs !== V_F) begin
            failures++;
            $display("FAIL start_fetch got %b want %b", obs, V_F);
        end
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 0, 0);
            want = (8'h80 >> (k % 5)) | 8'h04;
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL basic_phase k=%0d got %b want %b", k, obs, want);
            end
        end
        checks++;
        if (ir !== 64'd4 || cc !== 64'd20) begin
            failures++;
            $display("FAIL basic_cnt got ir=%0d cc=%0d want 4/20", ir, cc);
        end
    endtask

    task automatic test_stall_execute();
        logic [63:0] ir0, cc0;
        int          n_ex;
        ir0 = ir; cc0 = cc;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        n_ex = pe ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 5'($urandom) | 5'b00100);
            if (pe) n_ex++;
        end
        step(0, 0, 0, 5'($urandom) & 5'b11011);
        checks++;
        if (n_ex !== 4 || obs !== V_M) begin
            failures++;
            $display("FAIL stall_ex got n=%0d vec=%b want 4 %b", n_ex, obs, V_M);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        checks++;
        if (obs !== V_F || ir !== ir0 + 1 || cc !== cc0 + 8) begin
            failures++;
            $display("FAIL stall_ex_len got %b ir=%0d cc=%0d want %b ir=%0d cc=%0d",
                     obs, ir, cc, V_F, ir0 + 1, cc0 + 8);
        end
    endtask

    task automatic test_halt();
        logic [63:0] ir0, cc0;
        ir0 = ir;
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        checks++;
        if (obs !== V_W) begin
            failures++;
            $display("FAIL halt_wb got %b want %b", obs, V_W);
        end
        step(0, 0, 0, 0);
        checks++;
        if (obs !== V_H || ir !== ir0 + 1) begin
            failures++;
            $display("FAIL halt_enter got %b ir=%0d want %b ir=%0d", obs, ir, V_H, ir0 + 1);
        end
        cc0 = cc;
        step(0, 0, 1, 5'h1f);
        checks++;
        if (obs !== V_H || cc !== cc0) begin
            failures++;
            $display("FAIL halt_hold got %b cc=%0d want %b cc=%0d", obs, cc, V_H, cc0);
        end
        step(0, 1, 0, 0);
        checks++;
        if (obs !== V_F) begin
            failures++;
            $display("FAIL halt_restart got %b want %b", obs, V_F);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 5'b10000);
        checks++;
        if (obs !== V_W) begin
            failures++;
            $display("FAIL halt_wbstall got %b want %b", obs, V_W);
        end
        step(0, 0, 0, 0);
        checks++;
        if (obs !== V_H) begin
            failures++;
            $display("FAIL halt_after_wbstall got %b want %b", obs, V_H);
        end
        step(0, 1, 0, 0);
    endtask

    task automatic test_watchdog();
        logic [63:0] ir0, cc0;
        ir0 = ir; cc0 = cc;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 5'b01000);
        checks++;
        if (obs !== V_M) begin
            failures++;
            $display("FAIL wdt_pre got %b want %b", obs, V_M);
        end
        step(0, 0, 0, 5'b01000);
        checks++;
        if (obs !== V_HT || ir !== ir0 || cc !== cc0 + 7) begin
            failures++;
            $display("FAIL wdt_trip got %b ir=%0d cc=%0d want %b ir=%0d cc=%0d",
                     obs, ir, cc, V_HT, ir0, cc0 + 7);
        end
        step(0, 1, 0, 5'b01000);
        checks++;
        if (obs !== V_F) begin
            failures++;
            $display("FAIL wdt_clear got %b want %b", obs, V_F);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 5'b00100);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 5'b00100);
        checks++;
        if (obs !== V_HT) begin
            failures++;
            $display("FAIL wdt_with_halt got %b want %b", obs, V_HT);
        end
        step(0, 1, 0, 0);
    endtask

    task automatic test_wrap();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 85; i++) step(0, 0, 0, 0);
        checks++;
        if (ir_n !== 4'd1 || cc_n !== 4'd5) begin
            failures++;
            $display("FAIL wrap_narrow got ir=%0d cc=%0d want 1/5", ir_n, cc_n);
        end
        checks++;
        if (ir !== 64'd17 || cc !== 64'd85) begin
            failures++;
            $display("FAIL wrap_wide got ir=%0d cc=%0d want 17/85", ir, cc);
        end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        checks++;
        if (obs !== V_M) begin
            failures++;
            $display("FAIL rstmid_pre got %b want %b", obs, V_M);
        end
        step(1, 1, 0, 0);
        checks++;
        if (obs !== 8'h00 || cc !== 64'd0 || ir !== 64'd0 || obs_n !== 8'h00) begin
            failures++;
            $display("FAIL rstmid got %b cc=%0d ir=%0d want 0", obs, cc, ir);
        end
        step(0, 0, 0, 0);
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL rstmid_idle got %b want 00000000", obs);
        end
    endtask

    task automatic test_random();
        logic       r, s, h;
        logic [4:0] stl;
        int         mode;
        mode = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 24 == 0) mode = $urandom_range(0, 3);
            r = ($urandom_range(0, 149) == 0);
            s = ($urandom_range(0, 7) == 0);
            h = ($urandom_range(0, 24) == 0);
            for (int b = 0; b < 5; b++)
                stl[b] = (mode == 0) ? ($urandom_range(0, 3) != 0)
                                     : ($urandom_range(0, 3) == 0);
            step(r, s, h, stl);
            checks++;
            if (obs !== mdl_vec() || obs_n !== mdl_vec()) begin
                failures++;
                $display("FAIL rand_vec i=%0d got %b/%b want %b", i, obs, obs_n, mdl_vec());
            end
            checks++;
            if (cc !== m_cc || ir !== m_ir || cc_n !== m_cc[3:0] || ir_n !== m_ir[3:0]) begin
                failures++;
                $display("FAIL rand_cnt i=%0d got cc=%0d ir=%0d want cc=%0d ir=%0d",
                         i, cc, ir, m_cc, m_ir);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt_req = 1'b0; st = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall_execute();
        test_halt();
        test_watchdog();
        test_wrap();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Multicycle core controller that sequences the five instruction phases (fetch, decode, execute, memory access, writeback) as a one-hot phase vector. It honours per-stage stall requests such as `stall_execute` from the execute stage, supports start/halt control, and guards against stuck stalls with a watchdog. It sits in the core top beside the stage modules, and its phase outputs drive their `phase_*` inputs directly. It also keeps cycle and retired-instruction counters for later CSR use.

## Interface
- `CNT_W`, default 64: width of `cycle_count` and `instret`.
- `WDT_LIMIT`, default 255: consecutive stall cycles in one phase that trip the watchdog; must be ≥1.
- `clk`  in  1  global clock.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `start`  in  1  level; leaves IDLE or HALT.
- `halt_req`  in  1  request to stop after the current instruction retires.
- `stall_fetch`, `stall_decode`, `stall_execute`, `stall_memoryaccess`, `stall_writeback`  in  1 each  hold the corresponding phase.
- `phase_fetch`, `phase_decode`, `phase_execute`, `phase_memoryaccess`, `phase_writeback`  out  1 each  registered one-hot phase.
- `busy`  out  1  high in any of the five phase states.
- `halted`  out  1  high in HALT.
- `timeout`  out  1  sticky watchdog flag.
- `cycle_count`  out  CNT_W  count of busy cycles.
- `instret`  out  CNT_W  count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMACC, WB, HALT. The phase outputs are a registered one-hot decode of state. All five are 0 in IDLE and HALT.
- IDLE: `start`=1 goes to FETCH; otherwise stay.
- Phase state X: if `stall_X`=1, stay. Otherwise advance: FETCH→DECODE→EXECUTE→MEMACC→WB.
- WB with `stall_writeback`=0 retires the instruction (`instret`+1) and then:
  - goes to HALT if halt is pending or `halt_req`=1 this cycle;
  - else goes to FETCH.
- Stall inputs of non-active phases are ignored.
- Halt pending: set when `halt_req`=1 in any busy state; cleared on entry to HALT. `halt_req` in IDLE or HALT is ignored.
- HALT: `start`=1 goes to FETCH, resuming with a fresh instruction, and clears `timeout`.
- Watchdog: an internal counter is cleared on every state change and increments each cycle the active phase is stalled. When the counter reaches `WDT_LIMIT` while still stalled, the next state is HALT and `timeout` is set. This does not increment `instret`.
- `cycle_count` increments every cycle `busy`=1, including stalled cycles.
- Both counters wrap modulo 2^CNT_W silently.
- `start` while busy is ignored.

## Timing
- Reset values:
  - state IDLE;
  - all `phase_*`=0, `busy`=0, `halted`=0, `timeout`=0;
  - `cycle_count`=0, `instret`=0;
  - halt pending and watchdog counter cleared.
- `rst` takes effect at the next `clk` edge from any state, including mid-instruction; it overrides `start`.
- `start` sampled high at edge N gives `phase_fetch`=1 during cycle N+1.
- With no stalls, each phase is 1 cycle and an instruction takes 5 cycles; the fetch after WB is back-to-back.
- A stall of k cycles in phase X extends X to k+1 cycles.
- Stall inputs are combinational from the stages and sampled at the edge ending the cycle.
- `instret` updates at the edge leaving WB. It is visible in the same cycle that `phase_fetch` or `halted` rises.
- The watchdog trips at the edge that ends the `WDT_LIMIT`-th consecutive stalled cycle. `halted` and `timeout` rise together in the next cycle.
- Simultaneous events:
  - `halt_req` and a stalled WB: halt is taken when WB completes.
  - Watchdog trip and halt pending together: HALT with `timeout`=1.
  - `start` and `halt_req` in IDLE: start wins; the later `halt_req` is then honoured after one instruction.

## Test plan
- Reset, then `start` pulse, no stalls, 20 cycles → phases cycle fetch..writeback with period 5; `instret`=4, `cycle_count`=20 at end of cycle 20 after start.
- `stall_execute`=1 for 3 cycles during EXECUTE → `phase_execute` high for 4 cycles; `stall_fetch` toggling during EXECUTE has no effect; instruction takes 8 cycles.
- `halt_req` pulse during DECODE → sequence completes through WB, `halted`=1 next cycle, `instret`+1; `start` → `phase_fetch`=1 next cycle.
- `WDT_LIMIT`=4, `stall_memoryaccess` held 1 → after 4 stalled MEMACC cycles `halted`=1 and `timeout`=1; `instret` unchanged; `start` clears `timeout`.
- `CNT_W`=4, run 17 instructions → `instret` wraps to 1; `cycle_count` wraps modulo 16.
- `rst`=1 during MEMACC → next cycle all `phase_*`=0, counters 0, state IDLE; `start` in the same cycle as `rst` is ignored.
